// File: rtl/cache_types_pkg.sv
// Shared cache-interface types: line/burst geometry and the line adaptor state encoding.
package cache_types_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W       = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_e;

endpackage : cache_types_pkg

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// One line buffer serves both read assembly and write slicing.
module cacheline_adaptor
    import cache_types_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    adaptor_state_e         state_r;
    adaptor_state_e         state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [LINE_WIDTH-1:0]  line_r;
    logic [31:0]            addr_r;
    logic                   last_beat_s;

    assign last_beat_s = resp_i && (cnt_r == CNT_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; read takes priority when both requests are raised
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (read_i) begin
                    state_s = RD;
                end else if (write_i) begin
                    state_s = WR;
                end else begin
                    state_s = IDLE;
                end
            end
            RD, WR: begin
                if (last_beat_s) begin
                    state_s = DONE;
                end else begin
                    state_s = state_r;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Address latch, line buffer and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            line_r <= '0;
            addr_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (read_i) begin
                        addr_r <= {address_i[31:5], 5'b0_0000};
                    end else if (write_i) begin
                        addr_r <= {address_i[31:5], 5'b0_0000};
                        line_r <= line_i;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_r[cnt_r*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Memory-side outputs decode only from registered state, never from cache inputs
    assign read_o    = (state_r == RD);
    assign write_o   = (state_r == WR);
    assign resp_o    = (state_r == DONE);
    assign address_o = addr_r;
    assign line_o    = line_r;
    assign burst_o   = line_r[cnt_r*BURST_WIDTH +: BURST_WIDTH];

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: table of line transactions with per-cycle
// resp_i patterns, plus hand sequences for reset mid-burst and ignored strobes.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int total = 0;
    int bad   = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_write;
        logic         both;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] line;
        logic [7:0]   pat;      // resp_i per burst cycle, LSB first; 1 beyond bit 7
        int           exp_cyc;  // burst cycles until the fourth beat
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int bnum = 0;
        int cyc  = 0;
        @(negedge clk);
        address_i = v.addr;
        line_i    = v.is_write ? v.line : ~v.line;
        read_i    = !v.is_write;
        write_i   = v.is_write || v.both;
        resp_i    = 1'b0;
        @(posedge clk);
        while (bnum < 4 && cyc < 40) begin
            @(negedge clk);
            check("read_o", read_o, !v.is_write);
            check("write_o", write_o, v.is_write);
            check("address_o", address_o, v.exp_addr);
            check("resp_o_busy", resp_o, 1'b0);
            if (v.is_write) begin
                check("burst_o", burst_o, v.line[bnum*64 +: 64]);
            end
            resp_i  = (cyc < 8) ? v.pat[cyc] : 1'b1;
            burst_i = resp_i ? v.line[bnum*64 +: 64] : ~v.line[bnum*64 +: 64];
            cyc++;
            @(posedge clk);
            if (resp_i) bnum++;
        end
        @(negedge clk);
        check("burst_cycles", cyc, v.exp_cyc);
        check("resp_o_done", resp_o, 1'b1);
        check("read_o_done", read_o, 1'b0);
        check("write_o_done", write_o, 1'b0);
        if (!v.is_write) begin
            check("line_o_done", line_o, v.line);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        check("resp_o_idle", resp_o, 1'b0);
        check("read_o_idle", read_o, 1'b0);
        check("write_o_idle", write_o, 1'b0);
        if (!v.is_write) begin
            check("line_o_hold", line_o, v.line);
        end
        resp_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h1234_567C, 32'h1234_5660,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                    8'hFF, 4};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040,
                    {4'h0, {62{4'hF}}, 4'h0}, 8'hFF, 4};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                    256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD,
                    8'h59, 7};
        vecs[3] = '{1'b0, 1'b1, 32'h8000_001F, 32'h8000_0000,
                    256'h0102030405060708_1112131415161718_2122232425262728_3132333435363738,
                    8'hFF, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_1000,
                    256'h0123012301230123_4567456745674567_89AB89AB89AB89AB_CDEFCDEFCDEFCDEF,
                    8'h36, 6};

        rst_n     = 1'b0;
        line_i    = 256'h0;
        address_i = 32'h0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = 64'h0;
        resp_i    = 1'b0;
        #1;
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_line_o", line_o, 256'h0);
        check("rst_address_o", address_o, 32'h0);
        check("rst_burst_o", burst_o, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
        end

        // Reset asserted between edges after two captured read beats
        @(negedge clk);
        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = 64'h5555_0000_0000_0000 + 64'(b);
            @(posedge clk);
        end
        @(negedge clk);
        resp_i = 1'b0;
        check("mid_read_o", read_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_read_o", read_o, 1'b0);
        check("arst_line_o", line_o, 256'h0);
        check("arst_address_o", address_o, 32'h0);
        check("arst_resp_o", resp_o, 1'b0);
        read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[0]);

        // resp_i strobed while idle must not start anything or disturb line_o
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = 64'h9999_9999_9999_9999;
        @(negedge clk);
        resp_i = 1'b0;
        check("idle_strobe_resp_o", resp_o, 1'b0);
        check("idle_strobe_read_o", read_o, 1'b0);
        check("idle_strobe_write_o", write_o, 1'b0);
        check("idle_strobe_line_o", line_o, vecs[0].line);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cacheline_adaptor
